// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, state encoding and op decode helpers for muldiv_unit
package muldiv_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int WIDTH_ITER = 32;

    // muldiv_step mode select
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // DIV/REM and MULH/MULHSU treat rs1 as signed. MUL is handled as
    // unsigned: the low product word is identical either way.
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3 == F3_MULH || f3 == F3_MULHSU);
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3 == F3_MULH);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring-divide iteration
// Ports:
//   acc_i     : current accumulator {hi, lo}
//   operand_i : multiplicand (multiply) or divisor magnitude (divide)
//   mode_i    : MODE_MUL or MODE_DIV
//   acc_o     : accumulator after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               mode_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: lo holds the unconsumed multiplier bits; add into hi when
        // the current bit is set, then shift the carry-extended pair right.
        sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);

        // Divide: {remainder, dividend} shifted left by one; the trial
        // subtract sees the remainder concatenated with the next dividend bit.
        // That value is below 2*divisor, so bit WIDTH of the difference is a
        // clean borrow flag.
        diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, operand_i};

        if (mode_i == MODE_MUL) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit feeding the register file write port
// Ports:
//   CLK, RST     : clock, asynchronous active-high reset
//   Start        : request, accepted only in IDLE
//   Funct3       : RV32M operation
//   Op_A, Op_B   : rs1 / rs2 values, latched on acceptance
//   Add_Dest     : rd index, latched on acceptance
//   Busy         : operation in flight (acceptance edge through end of DONE)
//   Done         : one-cycle completion pulse
//   Result       : registered result, held between Done pulses
//   Dest_Out     : registered rd
//   Write_En_Out : Done qualified by rd != 0
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] Op_A,
    input  logic [WIDTH-1:0] Op_B,
    input  logic [4:0]       Add_Dest,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       Dest_Out,
    output logic             Write_En_Out
);

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_ITER - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [4:0]         dest_q, dest_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [2*WIDTH-1:0] step_acc;
    logic               in_neg_a, in_neg_b, in_div;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               signs_differ;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_result;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .mode_i    (f3_is_div(f3_q) ? MODE_DIV : MODE_MUL),
        .acc_o     (step_acc)
    );

    // Operand magnitudes; negating MIN_NEG wraps to itself, which is the
    // correct unsigned magnitude.
    always_comb begin
        in_div   = f3_is_div(Funct3);
        in_neg_a = f3_a_signed(Funct3) & Op_A[WIDTH-1];
        in_neg_b = f3_b_signed(Funct3) & Op_B[WIDTH-1];
        abs_a    = in_neg_a ? -Op_A : Op_A;
        abs_b    = in_neg_b ? -Op_B : Op_B;
    end

    // Sign correction and result selection applied in FIX
    always_comb begin
        signs_differ = neg_a_q ^ neg_b_q;
        prod_fix     = signs_differ ? -acc_q : acc_q;
        quo_fix      = signs_differ ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix      = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (f3_is_div(f3_q)) begin
            fix_result = f3_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_result = (f3_q == F3_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        dest_d    = dest_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    f3_d    = Funct3;
                    dest_d  = Add_Dest;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    cnt_d   = '0;
                    state_d = CALC;
                    if (in_div) begin
                        operand_d = abs_b;
                        acc_d     = {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        operand_d = abs_a;
                        acc_d     = {{WIDTH{1'b0}}, abs_b};
                    end
                    // Divide-by-zero and signed overflow bypass the iterations
                    if (in_div && Op_B == '0) begin
                        result_d = Funct3[1] ? Op_A : ALL_ONES;
                        state_d  = DONE;
                    end else if (in_div && !Funct3[0] && Op_A == MIN_NEG && Op_B == ALL_ONES) begin
                        result_d = Funct3[1] ? '0 : MIN_NEG;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_result;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            dest_q    <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            operand_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            dest_q    <= dest_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
        end
    end

    assign Busy         = (state_q != IDLE);
    assign Done         = (state_q == DONE);
    assign Result       = result_q;
    assign Dest_Out     = dest_q;
    assign Write_En_Out = Done && (dest_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] Op_A, Op_B;
    logic [4:0]  Add_Dest;
    logic        Busy, Done;
    logic [31:0] Result;
    logic [4:0]  Dest_Out;
    logic        Write_En_Out;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Start        (Start),
        .Funct3       (Funct3),
        .Op_A         (Op_A),
        .Op_B         (Op_B),
        .Add_Dest     (Add_Dest),
        .Busy         (Busy),
        .Done         (Done),
        .Result       (Result),
        .Dest_Out     (Dest_Out),
        .Write_En_Out (Write_En_Out)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Pushes the expectation, issues one request from an idle unit, scrambles
    // the operand inputs after acceptance, and reports what the DUT produced.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] er, input int el,
                         output logic [31:0] o_res, output logic [4:0] o_rd, output logic o_we,
                         output int o_lat, output logic o_busy_after);
        exp_t e;
        e.res = er; e.rd = rd; e.we = (rd != 5'd0); e.lat = el;
        exp_q.push_back(e);
        Funct3 = f3; Op_A = a; Op_B = b; Add_Dest = rd; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0; Op_A = $urandom; Op_B = $urandom; Add_Dest = 5'($urandom);
        o_lat = 1;
        while (Done !== 1'b1 && o_lat < 100) begin
            @(posedge CLK); #1;
            o_lat++;
        end
        o_res = Result; o_rd = Dest_Out; o_we = Write_En_Out;
        if (Done !== 1'b1) o_lat = -1;
        @(posedge CLK); #1;
        o_busy_after = Busy | Done;
    endtask

    task automatic test_reset();
        RST = 1'b1; Start = 1'b0; Funct3 = '0; Op_A = '0; Op_B = '0; Add_Dest = '0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({Busy, Done, Result, Dest_Out, Write_En_Out} !== 40'd0)
            $display("FAIL reset_state got busy=%b done=%b res=%h rd=%0d we=%b want all 0",
                     Busy, Done, Result, Dest_Out, Write_En_Out);
        else passed++;
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if ({Busy, Done} !== 2'b00) $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", Busy, Done);
        else passed++;
    endtask

    task automatic test_mul();
        logic [2:0]  tf[4];
        logic [31:0] ta[4], tb[4], tr[4];
        logic [31:0] r; logic [4:0] d; logic w, ba; int lat; exp_t e;
        tf = '{3'b000, 3'b011, 3'b001, 3'b010};
        ta = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tb = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        tr = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(tf[i], ta[i], tb[i], 5'(i + 5), tr[i], 34, r, d, w, lat, ba);
            e = exp_q.pop_front();
            checks++;
            if ({r, d, w} !== {e.res, e.rd, e.we})
                $display("FAIL mul[%0d] res/rd/we got %h/%0d/%b want %h/%0d/%b", i, r, d, w, e.res, e.rd, e.we);
            else passed++;
            checks++;
            if (lat !== e.lat) $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, e.lat);
            else passed++;
            checks++;
            if (ba !== 1'b0) $display("FAIL mul_idle_after[%0d] got busy|done=%b want 0", i, ba);
            else passed++;
        end
    endtask

    task automatic test_div();
        logic [2:0]  tf[8];
        logic [31:0] ta[8], tb[8], tr[8];
        int          tl[8];
        logic [31:0] r; logic [4:0] d; logic w, ba; int lat; exp_t e;
        tf = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110};
        ta = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        tb = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tr = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        tl = '{34, 34, 34, 34, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            issue(tf[i], ta[i], tb[i], 5'(i + 10), tr[i], tl[i], r, d, w, lat, ba);
            e = exp_q.pop_front();
            checks++;
            if ({r, d, w} !== {e.res, e.rd, e.we})
                $display("FAIL div[%0d] res/rd/we got %h/%0d/%b want %h/%0d/%b", i, r, d, w, e.res, e.rd, e.we);
            else passed++;
            checks++;
            if (lat !== e.lat) $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, e.lat);
            else passed++;
            checks++;
            if (ba !== 1'b0) $display("FAIL div_idle_after[%0d] got busy|done=%b want 0", i, ba);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  f; logic [31:0] a, b, er; int el;
        logic [31:0] r; logic [4:0] d, rd; logic w, ba; int lat; exp_t e;
        for (int i = 0; i < 10; i++) begin
            f  = 3'($urandom);
            a  = $urandom;
            case ($urandom_range(3, 0))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(9, 1));
                default: b = $urandom;
            endcase
            rd = 5'($urandom);
            er = ref_model(f, a, b);
            el = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
            issue(f, a, b, rd, er, el, r, d, w, lat, ba);
            e = exp_q.pop_front();
            checks++;
            if ({r, d, w, lat} !== {e.res, e.rd, e.we, e.lat})
                $display("FAIL random[%0d] f3=%0d a=%h b=%h got %h/%0d/%b/lat%0d want %h/%0d/%b/lat%0d",
                         i, f, a, b, r, d, w, lat, e.res, e.rd, e.we, e.lat);
            else passed++;
        end
    endtask

    task automatic test_start_ignored();
        int n_done = 0; int first = -1; logic busy35 = 1'bx;
        logic [31:0] r = 'x; logic [4:0] d = 'x; logic w = 1'bx; exp_t e;
        e.res = 32'd42; e.rd = 5'd0; e.we = 1'b0; e.lat = 34;
        exp_q.push_back(e);
        Funct3 = 3'b000; Op_A = 32'd6; Op_B = 32'd7; Add_Dest = 5'd0; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            if (Done === 1'b1) begin
                n_done++;
                if (first < 0) begin first = n; r = Result; d = Dest_Out; w = Write_En_Out; end
            end
            if (n == 35) busy35 = Busy;
            Start = (n == 5 || n == 34);
            @(posedge CLK); #1;
        end
        Start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (n_done !== 1) $display("FAIL start_ignored_done_count got %0d want 1", n_done);
        else passed++;
        checks++;
        if (first !== e.lat) $display("FAIL start_ignored_latency got %0d want %0d", first, e.lat);
        else passed++;
        checks++;
        if ({r, d, w} !== {e.res, e.rd, e.we})
            $display("FAIL rd0_result res/rd/we got %h/%0d/%b want %h/%0d/%b", r, d, w, e.res, e.rd, e.we);
        else passed++;
        checks++;
        if (busy35 !== 1'b0) $display("FAIL start_during_done_busy got %b want 0", busy35);
        else passed++;
    endtask

    task automatic test_async_reset();
        int n_done = 0;
        logic [31:0] r; logic [4:0] d; logic w, ba; int lat; exp_t e;
        Funct3 = 3'b101; Op_A = 32'd100; Op_B = 32'd7; Add_Dest = 5'd9; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (14) begin @(posedge CLK); #1; end
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({Busy, Done, Result, Dest_Out, Write_En_Out} !== 40'd0)
            $display("FAIL async_reset got busy=%b done=%b res=%h rd=%0d we=%b want all 0",
                     Busy, Done, Result, Dest_Out, Write_En_Out);
        else passed++;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (Done === 1'b1) n_done++;
            @(posedge CLK); #1;
        end
        checks++;
        if (n_done !== 0) $display("FAIL aborted_op_done got %0d pulses want 0", n_done);
        else passed++;
        issue(3'b000, 32'd3, 32'd4, 5'd3, 32'd12, 34, r, d, w, lat, ba);
        e = exp_q.pop_front();
        checks++;
        if ({r, d, w, lat} !== {e.res, e.rd, e.we, e.lat})
            $display("FAIL mul_after_reset got %h/%0d/%b/lat%0d want %h/%0d/%b/lat%0d",
                     r, d, w, lat, e.res, e.rd, e.we, e.lat);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_random();
        test_start_ignored();
        test_async_reset();
        checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit that sits directly downstream of the register file. It consumes the two operand words read from the file and, after a multi-cycle computation, produces a result with a destination index and a write-enable. Those three outputs drive the register file's write port. The pipeline stalls on Busy while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported and verified.
CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  reset, asynchronous, active-high.
Start  in  1  request; sampled only in IDLE.
Funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
Op_A  in  WIDTH  rs1 value (register file read port A).
Op_B  in  WIDTH  rs2 value (register file read port B).
Add_Dest  in  5  rd index.
Busy  out  1  high from the edge accepting Start until the edge ending the DONE state.
Done  out  1  one-cycle pulse; Result and Dest_Out are valid while it is high.
Result  out  WIDTH  computed value; holds until the next Done.
Dest_Out  out  5  latched rd.
Write_En_Out  out  1  equals Done AND (Dest_Out != 0); drives the register file write enable.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, Busy=0, Done=0, Write_En_Out=0, Result=0, Dest_Out=0, counter=0. An operation in flight is discarded and produces no Done.
- IDLE, Start=1 at edge t0: latch Funct3, Add_Dest, sign flags, and the absolute operands. Signedness per op: MULH is signed x signed; MULHSU is signed x unsigned; DIV and REM are signed. Busy=1 from t0. Next state is CALC or, for the special cases below, DONE.
- CALC: 32 iterations on edges t1..t32.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring division producing quotient and remainder.
- FIX at edge t33: apply sign correction.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Select Result: MUL gives product[31:0]; MULH* give product[63:32]; DIV* give the quotient; REM* give the remainder.
  - Go to DONE.
- DONE: Done=1 for exactly one cycle (the cycle after t33). At edge t34 return to IDLE with Busy=0 and Done=0. Normal latency is Start edge to Done high = 34 cycles.
- Fast path: at t0, go directly to DONE, so Done is high in the cycle after t0.
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: result 0x80000000. REM of the same operands: result 0.
- Start while Busy: ignored, no queuing. The upstream stall must hold the instruction.
- Start and Done in the same cycle: the request is ignored. A new Start is accepted only in IDLE, i.e. the cycle after Done at the earliest.
- Operands are latched at t0. Changes on Op_A/Op_B afterwards have no effect.
- Result and Dest_Out are registered and stable between Done pulses.
- Arithmetic is modulo 2^WIDTH. The negation of 0x80000000 wraps to itself, which gives the correct unsigned magnitude.

Decomposition:
- Shared package holds:
  - Funct3 localparams (F3_MUL..F3_REMU).
  - FSM state encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - The constant WIDTH_ITER=32.
- One sub-module, muldiv_step: combinational single iteration with inputs accumulator, operand, and mode, output next accumulator. Used for both shift-add and restore-subtract.
- The FSM, counter, latches, and sign fix stay in muldiv_unit.

Test Plan:
- MUL: Op_A=7, Op_B=0xFFFFFFFD (-3), rd=5 -> Done at cycle 34, Result=0xFFFFFFEB, Write_En_Out=1, Dest_Out=5.
- MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH, same operands -> 0x00000000. MULHSU: 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV: -7 / 2 -> 0xFFFFFFFD (-3). REM, same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divisor 0: DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. All three with Done in the cycle after Start.
- Start pulsed again at cycles 5 and 34 during an operation -> both ignored, exactly one Done. rd=0 -> Done=1, Write_En_Out=0.
- Assert RST at cycle 15 of a DIV -> all outputs 0 immediately (asynchronous), no Done. A new MUL 3x4 after release -> 12.
